// File: rtl/smoll_bus_pkg.sv
// smoll_bus_pkg: shared types, constants and alignment check for the LSU bus master.
// No ports; imported by lsu_lane_align and lsu_bus_master.
package smoll_bus_pkg;
    typedef enum logic [1:0] {BYTE = 2'd0, HALF = 2'd1, WORD = 2'd2} lsu_size_e;
    typedef enum logic [1:0] {OK = 2'd0, MISALIGNED = 2'd1, TIMEOUT = 2'd2} lsu_err_e;
    typedef enum logic [1:0] {IDLE, REQ, WAIT, RESP} lsu_state_e;
    localparam logic [3:0] WSTRB_READ = 4'b0000;
    function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] off);
        return (size == 2'd3) || (size == HALF && off[0]) || (size == WORD && off != 2'b00);
    endfunction
endpackage

// File: rtl/lsu_bus_master_if.sv
// lsu_bus_master_if: valid/ready request, registered-response peripheral bus.
// master drives req_valid/req_addr/req_value/req_wstrb; slave drives req_ready/resp_valid/resp_value.
interface lsu_bus_master_if;
    logic        req_valid;
    logic [31:0] req_addr;
    logic [31:0] req_value;
    logic [3:0]  req_wstrb;
    logic        req_ready;
    logic        resp_valid;
    logic [31:0] resp_value;
    modport master (output req_valid, req_addr, req_value, req_wstrb,
                    input  req_ready, resp_valid, resp_value);
    modport slave  (input  req_valid, req_addr, req_value, req_wstrb,
                    output req_ready, resp_valid, resp_value);
endinterface

// File: rtl/lsu_lane_align.sv
// lsu_lane_align: combinational store strobe/lane replication and load extract/extension.
// st_*: core store offset/size/data in, byte strobes and replicated data out.
// ld_*: latched load offset/size/unsigned and raw bus word in, extended load data out.
module lsu_lane_align
    import smoll_bus_pkg::*;
(
    input  logic [1:0]  st_off_i,
    input  logic [1:0]  st_size_i,
    input  logic [31:0] st_wdata_i,
    output logic [3:0]  st_wstrb_o,
    output logic [31:0] st_value_o,
    input  logic [1:0]  ld_off_i,
    input  logic [1:0]  ld_size_i,
    input  logic        ld_unsigned_i,
    input  logic [31:0] ld_raw_i,
    output logic [31:0] ld_data_o
);
    logic [7:0]  ld_byte;
    logic [15:0] ld_half;
    logic        ld_sign;
    always_comb begin
        st_wstrb_o = st_size_i == BYTE ? 4'b0001 << st_off_i :
                     st_size_i == HALF ? (st_off_i[1] ? 4'b1100 : 4'b0011) :
                     st_size_i == WORD ? 4'b1111 : WSTRB_READ;
        st_value_o = st_size_i == BYTE ? {4{st_wdata_i[7:0]}} :
                     st_size_i == HALF ? {2{st_wdata_i[15:0]}} : st_wdata_i;
        ld_byte    = 8'(ld_raw_i >> {ld_off_i, 3'b000});
        ld_half    = ld_off_i[1] ? ld_raw_i[31:16] : ld_raw_i[15:0];
        ld_sign    = ~ld_unsigned_i & (ld_size_i == BYTE ? ld_byte[7] : ld_half[15]);
        ld_data_o  = ld_size_i == BYTE ? {{24{ld_sign}}, ld_byte} :
                     ld_size_i == HALF ? {{16{ld_sign}}, ld_half} : ld_raw_i;
    end
endmodule

// File: rtl/lsu_bus_master.sv
// lsu_bus_master: turns single core loads/stores into peripheral bus transactions.
// Ports: clk_i, rst_ni (async active-low); core_req_* request in, core_req_ready_o;
// core_resp_valid_o/core_rdata_o/core_err_o completion out; bus (master modport).
// LSU_TIMEOUT_EN: when defined, REQ+WAIT are bounded by TIMEOUT_CYCLES and fault with err=2.
module lsu_bus_master
    import smoll_bus_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 16
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        core_req_valid_i,
    output logic        core_req_ready_o,
    input  logic [31:0] core_addr_i,
    input  logic [31:0] core_wdata_i,
    input  logic        core_we_i,
    input  logic [1:0]  core_size_i,
    input  logic        core_unsigned_i,
    output logic        core_resp_valid_o,
    output logic [31:0] core_rdata_o,
    output logic [1:0]  core_err_o,
    lsu_bus_master_if.master bus
);
    if (TIMEOUT_CYCLES < 2) begin : g_bad_timeout
        $error("TIMEOUT_CYCLES must be at least 2");
    end

    lsu_state_e  state_q, state_d;
    lsu_err_e    err_q, err_d;
    logic        ready_q, ready_d, resp_valid_q, resp_valid_d;
    logic [31:0] rdata_q, rdata_d;
    logic        bvalid_q, bvalid_d;
    logic [31:0] baddr_q, baddr_d, bvalue_q, bvalue_d;
    logic [3:0]  bwstrb_q, bwstrb_d;
    logic [1:0]  off_q, off_d, size_q, size_d;
    logic        uns_q, uns_d, we_q, we_d;
    logic [3:0]  st_wstrb;
    logic [31:0] st_value, ld_data;
    logic        expired;

    lsu_lane_align u_lane_align (
        .st_off_i      (core_addr_i[1:0]),
        .st_size_i     (core_size_i),
        .st_wdata_i    (core_wdata_i),
        .st_wstrb_o    (st_wstrb),
        .st_value_o    (st_value),
        .ld_off_i      (off_q),
        .ld_size_i     (size_q),
        .ld_unsigned_i (uns_q),
        .ld_raw_i      (bus.resp_value),
        .ld_data_o     (ld_data)
    );

`ifdef LSU_TIMEOUT_EN
    localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES);
    logic [CNT_W-1:0] cnt_q, cnt_d;
    // Held at zero outside REQ/WAIT, so it is already cleared on REQ entry.
    always_comb cnt_d = (state_q == REQ || state_q == WAIT) ? cnt_q + CNT_W'(1) : '0;
    assign expired = cnt_q == CNT_W'(TIMEOUT_CYCLES - 1);
    always_ff @(posedge clk_i or negedge rst_ni)
        if (!rst_ni) cnt_q <= '0;
        else         cnt_q <= cnt_d;
`else
    assign expired = 1'b0;
`endif

    always_comb begin
        state_d      = state_q;
        ready_d      = ready_q;
        resp_valid_d = 1'b0;
        rdata_d      = rdata_q;
        err_d        = err_q;
        bvalid_d     = bvalid_q;
        baddr_d      = baddr_q;
        bvalue_d     = bvalue_q;
        bwstrb_d     = bwstrb_q;
        off_d        = off_q;
        size_d       = size_q;
        uns_d        = uns_q;
        we_d         = we_q;
        case (state_q)
            IDLE: if (core_req_valid_i) begin
                off_d   = core_addr_i[1:0];
                size_d  = core_size_i;
                uns_d   = core_unsigned_i;
                we_d    = core_we_i;
                ready_d = 1'b0;
                if (is_misaligned(core_size_i, core_addr_i[1:0])) begin
                    state_d      = RESP;
                    resp_valid_d = 1'b1;
                    err_d        = MISALIGNED;
                end else begin
                    state_d  = REQ;
                    bvalid_d = 1'b1;
                    baddr_d  = {core_addr_i[31:2], 2'b00};
                    bvalue_d = core_we_i ? st_value : '0;
                    bwstrb_d = core_we_i ? st_wstrb : WSTRB_READ;
                end
            end
            REQ: begin
                // Expiry beats acceptance; this abort is the only valid retraction.
                if (expired) begin
                    state_d      = RESP;
                    resp_valid_d = 1'b1;
                    err_d        = TIMEOUT;
                end else if (bus.req_ready) begin
                    state_d = WAIT;
                end
                if (expired || bus.req_ready) begin
                    bvalid_d = 1'b0;
                    baddr_d  = '0;
                    bvalue_d = '0;
                    bwstrb_d = WSTRB_READ;
                end
            end
            WAIT: if (bus.resp_valid) begin
                state_d      = RESP;
                resp_valid_d = 1'b1;
                rdata_d      = we_q ? '0 : ld_data;
            end else if (expired) begin
                state_d      = RESP;
                resp_valid_d = 1'b1;
                err_d        = TIMEOUT;
            end
            default: begin
                state_d = IDLE;
                ready_d = 1'b1;
                rdata_d = '0;
                err_d   = OK;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni)
        if (!rst_ni) begin
            state_q      <= IDLE;
            ready_q      <= 1'b1;
            resp_valid_q <= 1'b0;
            rdata_q      <= '0;
            err_q        <= OK;
            bvalid_q     <= 1'b0;
            baddr_q      <= '0;
            bvalue_q     <= '0;
            bwstrb_q     <= WSTRB_READ;
            off_q        <= '0;
            size_q       <= '0;
            uns_q        <= 1'b0;
            we_q         <= 1'b0;
        end else begin
            state_q      <= state_d;
            ready_q      <= ready_d;
            resp_valid_q <= resp_valid_d;
            rdata_q      <= rdata_d;
            err_q        <= err_d;
            bvalid_q     <= bvalid_d;
            baddr_q      <= baddr_d;
            bvalue_q     <= bvalue_d;
            bwstrb_q     <= bwstrb_d;
            off_q        <= off_d;
            size_q       <= size_d;
            uns_q        <= uns_d;
            we_q         <= we_d;
        end

    assign core_req_ready_o  = ready_q;
    assign core_resp_valid_o = resp_valid_q;
    assign core_rdata_o      = rdata_q;
    assign core_err_o        = err_q;
    assign bus.req_valid     = bvalid_q;
    assign bus.req_addr      = baddr_q;
    assign bus.req_value     = bvalue_q;
    assign bus.req_wstrb     = bwstrb_q;
endmodule

// File: tb/tb_lsu_bus_master.sv
// tb_lsu_bus_master: scoreboard bench for lsu_bus_master with directed vectors.
module tb_lsu_bus_master;
    import smoll_bus_pkg::*;

    logic        clk = 1'b0;
    logic        rst_ni = 1'b0;
    logic        core_req_valid_i = 1'b0;
    logic        core_req_ready_o;
    logic [31:0] core_addr_i = '0;
    logic [31:0] core_wdata_i = '0;
    logic        core_we_i = 1'b0;
    logic [1:0]  core_size_i = '0;
    logic        core_unsigned_i = 1'b0;
    logic        core_resp_valid_o;
    logic [31:0] core_rdata_o;
    logic [1:0]  core_err_o;

    always #5 clk = ~clk;

    lsu_bus_master_if bus ();

    lsu_bus_master #(.TIMEOUT_CYCLES(16)) dut (
        .clk_i             (clk),
        .rst_ni            (rst_ni),
        .core_req_valid_i  (core_req_valid_i),
        .core_req_ready_o  (core_req_ready_o),
        .core_addr_i       (core_addr_i),
        .core_wdata_i      (core_wdata_i),
        .core_we_i         (core_we_i),
        .core_size_i       (core_size_i),
        .core_unsigned_i   (core_unsigned_i),
        .core_resp_valid_o (core_resp_valid_o),
        .core_rdata_o      (core_rdata_o),
        .core_err_o        (core_err_o),
        .bus               (bus)
    );

    typedef struct {logic [31:0] rdata; logic [1:0] err; int cyc;} core_exp_t;
    typedef struct {logic [31:0] addr; logic [31:0] value; logic [3:0] wstrb;} bus_exp_t;

    core_exp_t   cq[$];
    bus_exp_t    bq[$];
    int          n_vec = 0, n_err = 0, n_resp = 0, cyc = 0, bus_valid_cycles = 0;
    logic        silent = 1'b0;
    int          stall = 0, inject_req = 0;
    logic [31:0] resp_data = '0;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Responder: ready after `stall` valid cycles, registered response one cycle after acceptance.
    initial begin
        logic hs_pending;
        int   vcnt, inject_seen;
        logic inj;
        hs_pending = 1'b0; vcnt = 0; inject_seen = 0;
        bus.req_ready = 1'b0; bus.resp_valid = 1'b0; bus.resp_value = '0;
        forever begin
            @(posedge clk); #1;
            inj = inject_req != inject_seen;
            inject_seen = inject_req;
            bus.resp_valid = (hs_pending && !silent) || inj;
            bus.resp_value = (hs_pending && !silent) ? resp_data : inj ? 32'hFFFF_FFFF : 32'h0;
            if (bus.req_valid) begin
                bus.req_ready = vcnt >= stall;
                vcnt++;
            end else begin
                bus.req_ready = 1'b0;
                vcnt = 0;
            end
            hs_pending = bus.req_valid && bus.req_ready;
        end
    end

    // Monitor: pops expectations whenever the DUT presents a response or a bus request.
    initial begin
        core_exp_t e;
        bus_exp_t  b;
        logic      pending;
        pending = 1'b0;
        forever begin
            @(negedge clk);
            if (rst_ni) begin
                if (core_resp_valid_o) begin
                    n_resp++;
                    if (cq.size() == 0) begin
                        n_vec++; n_err++;
                        $display("FAIL unexpected_resp: got rdata %0h err %0d at cycle %0d, expected none", core_rdata_o, core_err_o, cyc);
                    end else begin
                        e = cq.pop_front();
                        chk("resp_rdata", core_rdata_o, e.rdata);
                        chk("resp_err", core_err_o, e.err);
                        chk("resp_cycle", cyc, e.cyc);
                    end
                end
                if (bus.req_valid) begin
                    bus_valid_cycles++;
                    if (bq.size() == 0) begin
                        n_vec++; n_err++;
                        $display("FAIL unexpected_bus_req: got addr %0h at cycle %0d, expected none", bus.req_addr, cyc);
                    end else begin
                        b = bq[0];
                        chk("bus_addr", bus.req_addr, b.addr);
                        chk("bus_value", bus.req_value, b.value);
                        chk("bus_wstrb", bus.req_wstrb, b.wstrb);
                        if (bus.req_ready) begin
                            void'(bq.pop_front());
                            pending = 1'b0;
                        end else pending = 1'b1;
                    end
                end else if (pending) begin
                    void'(bq.pop_front());
                    pending = 1'b0;
                end
            end else pending = 1'b0;
        end
    end

    task automatic drive(input logic [31:0] a, input logic [31:0] wd, input logic we,
                         input logic [1:0] sz, input logic uns);
        core_req_valid_i = 1'b1; core_addr_i = a; core_wdata_i = wd;
        core_we_i = we; core_size_i = sz; core_unsigned_i = uns;
        @(posedge clk); #1;
        core_req_valid_i = 1'b0; core_addr_i = '0; core_wdata_i = '0;
        core_we_i = 1'b0; core_size_i = '0; core_unsigned_i = 1'b0;
    endtask

    task automatic op(input string name, input logic [31:0] a, input logic [31:0] wd, input logic we,
                      input logic [1:0] sz, input logic uns, input logic [31:0] er, input logic [1:0] ee,
                      input int lat, input logic bus_on, input logic [31:0] ba, input logic [31:0] bv,
                      input logic [3:0] bs);
        core_exp_t e;
        bus_exp_t  b;
        int        n0;
        bit        done;
        n0 = n_resp;
        done = 1'b0;
        if (bus_on) begin
            b.addr = ba; b.value = bv; b.wstrb = bs;
            bq.push_back(b);
        end
        e.rdata = er; e.err = ee; e.cyc = cyc + lat;
        cq.push_back(e);
        drive(a, wd, we, sz, uns);
        for (int i = 0; i < 40 && !done; i++) begin
            @(posedge clk);
            done = n_resp != n0;
        end
        if (!done) begin
            n_vec++; n_err++;
            $display("FAIL %s: got no core response in 40 cycles, expected one", name);
            cq.delete();
        end
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running, expected completion");
        $fatal(1);
    end

    initial begin
        int bvc0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_req_ready", core_req_ready_o, 1);
        chk("rst_core_out", {core_resp_valid_o, core_rdata_o, core_err_o}, 0);
        chk("rst_bus_out", {bus.req_valid, bus.req_addr, bus.req_value, bus.req_wstrb}, 0);
        rst_ni = 1'b1;
        @(posedge clk); #1;

        resp_data = 32'h1234_5678;
        op("word_load", 32'h0000_BFF8, 0, 0, WORD, 0, 32'h1234_5678, OK, 3, 1, 32'h0000_BFF8, 0, 4'b0000);
        resp_data = 32'hDEAD_BEEF;
        op("byte_store", 32'h4002, 32'hA5, 1, BYTE, 0, 0, OK, 3, 1, 32'h4000, 32'hA5A5_A5A5, 4'b0100);
        op("byte_store_hi", 32'h4003, 32'h1234_56C3, 1, BYTE, 0, 0, OK, 3, 1, 32'h4000, 32'hC3C3_C3C3, 4'b1000);
        op("half_store", 32'h4006, 32'h1234_BEEF, 1, HALF, 0, 0, OK, 3, 1, 32'h4004, 32'hBEEF_BEEF, 4'b1100);
        op("word_store", 32'h0100, 32'hCAFE_F00D, 1, WORD, 0, 0, OK, 3, 1, 32'h0100, 32'hCAFE_F00D, 4'b1111);
        resp_data = 32'h00A5_0000;
        op("lb_signed", 32'h4002, 0, 0, BYTE, 0, 32'hFFFF_FFA5, OK, 3, 1, 32'h4000, 0, 4'b0000);
        op("lbu", 32'h4002, 0, 0, BYTE, 1, 32'h0000_00A5, OK, 3, 1, 32'h4000, 0, 4'b0000);
        resp_data = 32'h0000_7F00;
        op("lb_positive", 32'h4001, 0, 0, BYTE, 0, 32'h0000_007F, OK, 3, 1, 32'h4000, 0, 4'b0000);
        resp_data = 32'h8001_0000;
        op("lh_signed", 32'h4006, 0, 0, HALF, 0, 32'hFFFF_8001, OK, 3, 1, 32'h4004, 0, 4'b0000);
        op("lhu", 32'h4006, 0, 0, HALF, 1, 32'h0000_8001, OK, 3, 1, 32'h4004, 0, 4'b0000);
        resp_data = 32'h8001_7FFF;
        op("lh_low", 32'h4004, 0, 0, HALF, 0, 32'h0000_7FFF, OK, 3, 1, 32'h4004, 0, 4'b0000);

        bvc0 = bus_valid_cycles;
        op("mis_half", 32'h4001, 0, 0, HALF, 0, 0, MISALIGNED, 1, 0, 0, 0, 0);
        op("mis_word", 32'h4002, 32'h55, 1, WORD, 0, 0, MISALIGNED, 1, 0, 0, 0, 0);
        op("mis_size3", 32'h4000, 0, 0, 2'd3, 0, 0, MISALIGNED, 1, 0, 0, 0, 0);
        chk("mis_no_bus", bus_valid_cycles - bvc0, 0);

        stall = 3;
        resp_data = 32'h0BAD_F00D;
        op("backpressure", 32'h2000, 0, 0, WORD, 0, 32'h0BAD_F00D, OK, 6, 1, 32'h2000, 0, 4'b0000);
        stall = 0;

        @(negedge clk);
        inject_req++;
        repeat (3) @(posedge clk);
        #1;

        silent = 1'b1;
`ifdef LSU_TIMEOUT_EN
        op("timeout", 32'h8000, 0, 0, WORD, 0, 0, TIMEOUT, 17, 1, 32'h8000, 0, 4'b0000);
        @(negedge clk); @(negedge clk);
        inject_req++;
        silent = 1'b0;
        repeat (4) @(posedge clk);
        #1;
`else
        begin
            bus_exp_t b;
            b.addr = 32'h8000; b.value = '0; b.wstrb = 4'b0000;
            bq.push_back(b);
            drive(32'h8000, 0, 0, WORD, 0);
            repeat (25) @(posedge clk);
            #1;
            chk("stuck_ready", core_req_ready_o, 0);
            chk("stuck_bus_idle", bus.req_valid, 0);
            rst_ni = 1'b0;
            @(posedge clk); #1;
            rst_ni = 1'b1;
            silent = 1'b0;
            @(posedge clk); #1;
        end
`endif

        begin
            bus_exp_t b;
            silent = 1'b1;
            b.addr = 32'h3000; b.value = '0; b.wstrb = 4'b0000;
            bq.push_back(b);
            drive(32'h3000, 0, 0, WORD, 0);
            @(posedge clk); #3;
            chk("wait_ready_low", core_req_ready_o, 0);
            rst_ni = 1'b0;
            #1;
            chk("async_rst_ready", core_req_ready_o, 1);
            chk("async_rst_core", {core_resp_valid_o, core_rdata_o, core_err_o}, 0);
            chk("async_rst_bus", {bus.req_valid, bus.req_addr, bus.req_value, bus.req_wstrb}, 0);
            @(posedge clk); #1;
            rst_ni = 1'b1;
            silent = 1'b0;
            repeat (6) @(posedge clk);
            #1;
        end

        resp_data = 32'h55AA_33CC;
        op("post_reset_load", 32'h0010, 0, 0, WORD, 0, 32'h55AA_33CC, OK, 3, 1, 32'h0010, 0, 4'b0000);
        chk("scoreboard_drained", cq.size() + bq.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
